fifo_queue: RTL and testbench
=============================

Name: fifo_queue

Overview:
- First-in-first-out buffer with a controller/datapath split. Writes enter at the tail; reads leave from the head, the opposite end of the storage.
- Shares the request/flag style of the team's stack block: single-cycle request pulses, full/empty flags and a synchronous init.
- Sits between a producer and a consumer that both speak the enq/deq pulse protocol.
- Each operation takes one request cycle plus one action cycle.

Parameters:
- WIDTH, 2, data word width in bits.
- LENGTH, 8, number of entries. LENGTH >= 2; need not be a power of two.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- init  input  1  synchronous clear of queue contents and state.
- enq  input  1  enqueue request, sampled only in IDLE.
- deq  input  1  dequeue request, sampled only in IDLE.
- data_in  input  WIDTH  word to enqueue; sampled in the cycle enq is accepted.
- data_out  output  WIDTH  last dequeued word; holds between reads.
- valid  output  1  one-cycle pulse: data_out was updated this cycle.
- busy  output  1  high whenever the FSM is not in IDLE.
- full  output  1  count == LENGTH.
- empty  output  1  count == 0.

Behaviour:
- State: mem[0:LENGTH-1]; wr_ptr and rd_ptr, each $clog2(LENGTH) bits; count, $clog2(LENGTH)+1 bits; latched word wbuf.
- Reset (rst=0, asynchronous):
  - FSM -> IDLE.
  - wr_ptr = rd_ptr = count = 0.
  - data_out = 0, valid = 0, so busy = 0, full = 0, empty = 1.
  - mem contents are not reset.
- Reset asserted mid-operation aborts the operation; no partial pointer update survives.
- init=1 at a clock edge (with rst high):
  - Same clear as reset, except data_out holds its value.
  - init has priority over enq/deq and over any in-flight state; the FSM goes straight to IDLE.
- FSM states: IDLE, WRITE, READ.
  - IDLE:
    - enq && !full: latch data_in into wbuf, go to WRITE.
    - else deq && !empty: go to READ.
    - else stay in IDLE.
    - enq has priority when both are high; the deq is dropped and must be re-requested.
  - WRITE (1 cycle): mem[wr_ptr] <= wbuf; wr_ptr advances; count +1; go to IDLE.
  - READ (1 cycle): data_out <= mem[rd_ptr]; valid = 1 on the following cycle (registered); rd_ptr advances; count -1; go to IDLE.
- Pointer advance: if ptr == LENGTH-1 then 0, else ptr+1. Explicit wrap; no reliance on modulo-2^n overflow.
- Latency:
  - enq in cycle N: word stored at the end of cycle N+1; full/empty reflect it from N+2.
  - deq in cycle N: data_out/valid updated at the edge ending cycle N+1.
  - Maximum throughput is one operation per 2 cycles.
- Requests while busy=1 are ignored. The requester must hold or re-issue them after busy falls.
- enq while full, and deq while empty, are dropped with no state change.
- full and empty are combinational from count only; they are never both 1.
- Ordering: words leave in exactly the order they were accepted, across any number of wraps.

Optional Feature:
- Macro: QUEUE_ERR_EN.
- When defined:
  - Adds output ports overflow_err (1) and underflow_err (1), both sticky.
  - overflow_err sets when enq is seen in IDLE while full (and enq wins priority).
  - underflow_err sets when deq is seen in IDLE while empty and no enq is accepted.
  - Both clear only on reset or init; they reset to 0.
- When undefined: the ports do not exist and dropped requests are silent. All other behaviour is identical.

Test Plan:
- Reset then enq 1,2,3 (data_in=2'b01,2'b10,2'b11, each request followed by one idle cycle), then 3 deqs -> valid pulses with data_out 1, 2, 3 in order; empty=1 at the end.
- 8 enqs of 0,1,2,3,0,1,2,3 -> full=1 after the 8th. 9th enq (data 2) dropped, count stays 8. With QUEUE_ERR_EN, overflow_err=1.
- Deq on empty queue -> no valid pulse, data_out unchanged, busy stays 0. With QUEUE_ERR_EN, underflow_err=1.
- Wrap sequence: 6 enq, 6 deq, 6 enq (values 3,2,1,0,3,2), 6 deq -> second batch reads back 3,2,1,0,3,2 with wr_ptr having wrapped.
- enq and deq asserted together in IDLE on a non-empty queue -> only the enqueue executes (WRITE state), count +1, no valid pulse.
- rst=0 pulsed during a WRITE cycle -> immediately empty=1, busy=0, data_out=0. Next enq/deq pair returns the new word, not stale data.

Source files
------------

// File: rtl/fifo_queue.sv
// Request/flag FIFO with a small IDLE/WRITE/READ controller: each enq or deq costs a
// request cycle plus one action cycle. Define QUEUE_ERR_EN for sticky overflow/underflow flags.
module fifo_queue #(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned LENGTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             init_i,
  input  logic             enq_i,
  input  logic             deq_i,
  input  logic [WIDTH-1:0] data_in_i,
  output logic [WIDTH-1:0] data_out_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             full_o,
`ifdef QUEUE_ERR_EN
  output logic             overflow_err_o,
  output logic             underflow_err_o,
`endif
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(LENGTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(LENGTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(LENGTH);

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  wbuf_q, wbuf_d;
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic              mem_we;
  logic [WIDTH-1:0]  mem_q [LENGTH];

`ifdef QUEUE_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
`endif

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastIdx) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o     = (count_q == FullCnt);
  assign empty_o    = (count_q == '0);
  assign busy_o     = (state_q != StIdle);
  assign data_out_o = data_out_q;
  assign valid_o    = valid_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wbuf_d     = wbuf_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    mem_we     = 1'b0;
`ifdef QUEUE_ERR_EN
    ovf_d      = ovf_q;
    unf_d      = unf_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (enq_i && !full_o) begin
          wbuf_d  = data_in_i;
          state_d = StWrite;
        end else if (deq_i && !empty_o) begin
          state_d = StRead;
        end
`ifdef QUEUE_ERR_EN
        if (enq_i && full_o) ovf_d = 1'b1;
        if (deq_i && empty_o && !(enq_i && !full_o)) unf_d = 1'b1;
`endif
      end
      StWrite: begin
        mem_we   = 1'b1;
        wr_ptr_d = next_ptr(wr_ptr_q);
        count_d  = count_q + CntW'(1);
        state_d  = StIdle;
      end
      StRead: begin
        data_out_d = mem_q[rd_ptr_q];
        valid_d    = 1'b1;
        rd_ptr_d   = next_ptr(rd_ptr_q);
        count_d    = count_q - CntW'(1);
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // init overrides everything in flight but keeps the last read word visible.
    if (init_i) begin
      state_d  = StIdle;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      mem_we   = 1'b0;
      data_out_d = data_out_q;
`ifdef QUEUE_ERR_EN
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wbuf_q     <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wbuf_q     <= wbuf_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_ptr_q] <= wbuf_q;
  end

`ifdef QUEUE_ERR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow_err_o  = ovf_q;
  assign underflow_err_o = unf_q;
`endif

endmodule

// File: tb/tb_fifo_queue.sv
// Scoreboard bench for fifo_queue: accepted enq words are queued and compared on each
// valid pulse; full/empty/busy are checked against a bench-side occupancy count.
module tb_fifo_queue;

  localparam int unsigned WIDTH  = 2;
  localparam int unsigned LENGTH = 8;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             init_i;
  logic             enq_i;
  logic             deq_i;
  logic [WIDTH-1:0] data_in_i;
  logic [WIDTH-1:0] data_out_o;
  logic             valid_o;
  logic             busy_o;
  logic             full_o;
  logic             empty_o;
`ifdef QUEUE_ERR_EN
  logic             overflow_err_o;
  logic             underflow_err_o;
`endif

  fifo_queue #(
    .WIDTH (WIDTH),
    .LENGTH(LENGTH)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .init_i         (init_i),
    .enq_i          (enq_i),
    .deq_i          (deq_i),
    .data_in_i      (data_in_i),
    .data_out_o     (data_out_o),
    .valid_o        (valid_o),
    .busy_o         (busy_o),
    .full_o         (full_o),
`ifdef QUEUE_ERR_EN
    .overflow_err_o (overflow_err_o),
    .underflow_err_o(underflow_err_o),
`endif
    .empty_o        (empty_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned      total = 0;
  int unsigned      bad   = 0;
  logic [WIDTH-1:0] sb[$];
  int unsigned      mcnt  = 0;
  logic [WIDTH-1:0] last_out = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_full"},  32'(full_o),  32'(mcnt == LENGTH));
    check({tag, "_empty"}, 32'(empty_o), 32'(mcnt == 0));
  endtask

  task automatic do_enq(input logic [WIDTH-1:0] d);
    logic acc;
    @(negedge clk_i);
    enq_i = 1'b1;
    data_in_i = d;
    acc = (mcnt < LENGTH);
    @(negedge clk_i);
    enq_i = 1'b0;
    check("enq_busy", 32'(busy_o), 32'(acc));
    if (acc) begin
      sb.push_back(d);
      mcnt++;
    end
    @(negedge clk_i);
    check("enq_novalid", 32'(valid_o), 32'(0));
    check_flags("enq");
  endtask

  task automatic do_deq();
    logic acc;
    @(negedge clk_i);
    deq_i = 1'b1;
    acc = (mcnt > 0);
    @(negedge clk_i);
    deq_i = 1'b0;
    check("deq_busy", 32'(busy_o), 32'(acc));
    check("deq_early_valid", 32'(valid_o), 32'(0));
    @(negedge clk_i);
    if (acc) begin
      last_out = sb.pop_front();
      mcnt--;
    end
    check("deq_valid", 32'(valid_o), 32'(acc));
    check("deq_data", 32'(data_out_o), 32'(last_out));
    check_flags("deq");
  endtask

  initial begin
    logic [WIDTH-1:0] wrap_vals [6];
    wrap_vals = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
    rst_ni = 1'b0;
    init_i = 1'b0;
    enq_i = 1'b0;
    deq_i = 1'b0;
    data_in_i = '0;
    repeat (2) @(negedge clk_i);
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_valid", 32'(valid_o), 32'(0));
    check("rst_data", 32'(data_out_o), 32'(0));
    check_flags("rst");
`ifdef QUEUE_ERR_EN
    check("rst_ovf", 32'(overflow_err_o), 32'(0));
    check("rst_unf", 32'(underflow_err_o), 32'(0));
`endif
    rst_ni = 1'b1;

    // Basic in-order traffic.
    do_enq(2'b01);
    do_enq(2'b10);
    do_enq(2'b11);
    repeat (3) do_deq();
    check("basic_empty", 32'(empty_o), 32'(1));

    // Fill to capacity, then one dropped enq.
    for (int i = 0; i < 8; i++) do_enq(WIDTH'(i % 4));
    check("fill_full", 32'(full_o), 32'(1));
    do_enq(2'd2);
    check("over_full", 32'(full_o), 32'(1));
`ifdef QUEUE_ERR_EN
    check("over_err", 32'(overflow_err_o), 32'(1));
`endif
    repeat (8) do_deq();

    // Dequeue from empty: no pulse, data_out holds.
    do_deq();
    check("under_data", 32'(data_out_o), 32'(3));
`ifdef QUEUE_ERR_EN
    check("under_err", 32'(underflow_err_o), 32'(1));
`endif

    // init clears state and sticky flags but keeps data_out.
    @(negedge clk_i);
    init_i = 1'b1;
    @(negedge clk_i);
    init_i = 1'b0;
    check("init_data_hold", 32'(data_out_o), 32'(3));
    check("init_busy", 32'(busy_o), 32'(0));
    check_flags("init");
`ifdef QUEUE_ERR_EN
    check("init_ovf", 32'(overflow_err_o), 32'(0));
    check("init_unf", 32'(underflow_err_o), 32'(0));
`endif

    // Wrap: second batch straddles the end of storage.
    for (int i = 0; i < 6; i++) do_enq(WIDTH'(i));
    repeat (6) do_deq();
    for (int i = 0; i < 6; i++) do_enq(wrap_vals[i]);
    repeat (6) do_deq();

    // enq and deq together: only the enqueue runs.
    do_enq(2'd1);
    @(negedge clk_i);
    enq_i = 1'b1;
    deq_i = 1'b1;
    data_in_i = 2'd2;
    @(negedge clk_i);
    enq_i = 1'b0;
    deq_i = 1'b0;
    check("both_busy", 32'(busy_o), 32'(1));
    sb.push_back(2'd2);
    mcnt++;
    @(negedge clk_i);
    check("both_novalid", 32'(valid_o), 32'(0));
    check("both_busy_done", 32'(busy_o), 32'(0));
    @(negedge clk_i);
    check("both_novalid2", 32'(valid_o), 32'(0));
    check_flags("both");
    repeat (2) do_deq();

    // Reset in the middle of a WRITE.
    @(negedge clk_i);
    enq_i = 1'b1;
    data_in_i = 2'd3;
    @(negedge clk_i);
    enq_i = 1'b0;
    check("midrst_busy_pre", 32'(busy_o), 32'(1));
    rst_ni = 1'b0;
    #1;
    check("midrst_empty", 32'(empty_o), 32'(1));
    check("midrst_busy", 32'(busy_o), 32'(0));
    check("midrst_data", 32'(data_out_o), 32'(0));
    sb.delete();
    mcnt = 0;
    last_out = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    do_enq(2'b10);
    do_deq();
    check("post_rst_data", 32'(data_out_o), 32'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so a wedged run still reports.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
